craft_subcells_serial: RTL and testbench

- Serialized SubCells layer for the 64-bit CRAFT round datapath.
- Accepts a full 64-bit state over a valid/ready handshake and substitutes it 16 bits (4 nibbles) per cycle, over 4 cycles, through one craft_sbox instance.
- Presents the substituted state downstream over a second valid/ready handshake.
- The CRAFT S-box is an involution, so the same block serves encryption and decryption.

---
 rtl/craft_subcells_serial.sv | 134 +++++++++++++
 tb/tb_craft_subcells_serial.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/craft_subcells_serial.sv
// rtl/craft_subcells_serial.sv - serialized CRAFT SubCells, 16 bits per cycle over 4 cycles
// The CRAFT S-box is an involution, so one datapath serves encryption and decryption.

module craft_sbox (
  input  logic [15:0] x,
  output logic [15:0] y
);

  function automatic logic [3:0] sbox4(input logic [3:0] n);
    case (n)
      4'h0: sbox4 = 4'hc;
      4'h1: sbox4 = 4'ha;
      4'h2: sbox4 = 4'hd;
      4'h3: sbox4 = 4'h3;
      4'h4: sbox4 = 4'he;
      4'h5: sbox4 = 4'hb;
      4'h6: sbox4 = 4'hf;
      4'h7: sbox4 = 4'h7;
      4'h8: sbox4 = 4'h8;
      4'h9: sbox4 = 4'h9;
      4'ha: sbox4 = 4'h1;
      4'hb: sbox4 = 4'h5;
      4'hc: sbox4 = 4'h0;
      4'hd: sbox4 = 4'h2;
      4'he: sbox4 = 4'h4;
      default: sbox4 = 4'h6;
    endcase
  endfunction

  always_comb begin
    y = '0;
    for (int i = 0; i < 4; i++) begin
      y[4*i +: 4] = sbox4(x[4*i +: 4]);
    end
  end

endmodule

module craft_subcells_serial #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [1:0]  cnt;
  logic [63:0] data_q;
  logic [1:0]  idx;
  logic [5:0]  base;
  logic [15:0] sb_in;
  logic [15:0] sb_out;

  assign idx  = MSB_FIRST ? (2'd3 - cnt) : cnt;
  assign base = {idx, 4'b0000};
  assign sb_in = data_q[base +: 16];

  craft_sbox u_sbox (
    .x (sb_in),
    .y (sb_out)
  );

  // DONE accepts a new state only when the current one is leaving the same cycle.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    end
  end

  assign out_data = data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      data_q    <= 64'd0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_q <= in_data;
            cnt    <= 2'd0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          data_q[base +: 16] <= sb_out;
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              data_q <= in_data;
              cnt    <= 2'd0;
              busy   <= 1'b1;
              state  <= RUN;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_craft_subcells_serial.sv
// tb/tb_craft_subcells_serial.sv - directed bench for craft_subcells_serial, both chunk orders

module tb_craft_subcells_serial;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = 64'd0;
  logic        out_ready = 1'b0;
  logic        in_ready0, in_ready1;
  logic        out_valid0, out_valid1;
  logic [63:0] out_data0, out_data1;
  logic        busy0, busy1;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] V_ZERO = 64'h0000000000000000;
  localparam logic [63:0] V_ONES = 64'hFFFFFFFFFFFFFFFF;
  localparam logic [63:0] V_CNT  = 64'h0123456789ABCDEF;
  localparam logic [63:0] S_ZERO = 64'hCCCCCCCCCCCCCCCC;
  localparam logic [63:0] S_ONES = 64'h6666666666666666;
  localparam logic [63:0] S_CNT  = 64'hCAD3EBF789150246;

  always #5 clk = ~clk;

  craft_subcells_serial #(.MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .busy(busy0)
  );

  craft_subcells_serial #(.MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .busy(busy1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept d from IDLE, measure latency and busy length, check result, then complete handshake.
  task automatic xfer(input logic [63:0] d, input logic [63:0] exp, input string name);
    int n = 0;
    int bc = 0;
    in_valid = 1'b1;
    in_data = d;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data = 64'hDEADBEEFDEADBEEF;
    while (!out_valid0 && n < 20) begin
      if (busy0) bc++;
      tick();
      n++;
    end
    checks++;
    if (n !== 4) begin errors++; $display("FAIL %s latency: got %0d expected 4", name, n); end
    checks++;
    if (bc !== 4) begin errors++; $display("FAIL %s busy_cycles: got %0d expected 4", name, bc); end
    checks++;
    if (out_data0 !== exp) begin errors++; $display("FAIL %s data_lsb_first: got %h expected %h", name, out_data0, exp); end
    checks++;
    if (out_data1 !== exp || out_valid1 !== 1'b1) begin
      errors++; $display("FAIL %s data_msb_first: got %h/%b expected %h/1", name, out_data1, out_valid1, exp);
    end
    tick();
    checks++;
    if (out_valid0 !== 1'b0 || busy0 !== 1'b0 || in_ready0 !== 1'b1) begin
      errors++; $display("FAIL %s post_handshake: got ov=%b busy=%b ir=%b expected 0 0 1", name, out_valid0, busy0, in_ready0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready0 !== 1'b0 || in_ready1 !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready_forced: got %b%b expected 00", in_ready0, in_ready1);
    end
    tick();
    tick();
    checks++;
    if (out_valid0 !== 1'b0 || busy0 !== 1'b0 || out_data0 !== 64'd0) begin
      errors++; $display("FAIL reset_outputs: got ov=%b busy=%b data=%h expected 0 0 0", out_valid0, busy0, out_data0);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1) begin
      errors++; $display("FAIL reset_release_in_ready: got %b%b expected 11", in_ready0, in_ready1);
    end
    tick();
  endtask

  task automatic test_zero();
    xfer(V_ZERO, S_ZERO, "zero");
  endtask

  task automatic test_involution();
    xfer(V_CNT, S_CNT, "count_fwd");
    xfer(S_CNT, V_CNT, "count_inv");
  endtask

  task automatic test_backpressure();
    int n = 0;
    in_valid = 1'b1;
    in_data = V_ONES;
    out_ready = 1'b0;
    tick();
    in_data = V_ZERO;
    while (!out_valid0 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 4) begin errors++; $display("FAIL bp_latency: got %0d expected 4", n); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid0 !== 1'b1 || out_data0 !== S_ONES || in_ready0 !== 1'b0 || out_data1 !== S_ONES) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got ov=%b data=%h/%h ir=%b expected 1 %h 0", i, out_valid0, out_data0, out_data1, in_ready0, S_ONES);
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready0 !== 1'b1) begin errors++; $display("FAIL bp_in_ready_follows_out_ready: got %b expected 1", in_ready0); end
    tick();
    checks++;
    if (out_valid0 !== 1'b0 || busy0 !== 1'b0) begin
      errors++; $display("FAIL bp_release: got ov=%b busy=%b expected 0 0", out_valid0, busy0);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] vin [3];
    logic [63:0] vexp [3];
    int oc [3];
    int k_in = 0;
    int k_out = 0;
    int cyc = 0;
    logic acc;
    vin[0] = V_ZERO; vin[1] = V_ONES; vin[2] = V_CNT;
    vexp[0] = S_ZERO; vexp[1] = S_ONES; vexp[2] = S_CNT;
    in_valid = 1'b1;
    in_data = vin[0];
    out_ready = 1'b1;
    while (k_out < 3 && cyc < 40) begin
      acc = in_ready0 & in_valid;
      tick();
      cyc++;
      if (acc) begin
        k_in++;
        if (k_in < 3) in_data = vin[k_in];
        else in_valid = 1'b0;
      end
      if (out_valid0) begin
        checks++;
        if (out_data0 !== vexp[k_out] || out_data1 !== vexp[k_out]) begin
          errors++; $display("FAIL b2b_data[%0d]: got %h/%h expected %h", k_out, out_data0, out_data1, vexp[k_out]);
        end
        oc[k_out] = cyc;
        k_out++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (k_out !== 3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", k_out); end
    else begin
      checks++;
      if (oc[1] - oc[0] !== 5) begin errors++; $display("FAIL b2b_spacing01: got %0d expected 5", oc[1] - oc[0]); end
      checks++;
      if (oc[2] - oc[1] !== 5) begin errors++; $display("FAIL b2b_spacing12: got %0d expected 5", oc[2] - oc[1]); end
    end
    tick();
    checks++;
    if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) begin
      errors++; $display("FAIL b2b_idle: got ov=%b ir=%b expected 0 1", out_valid0, in_ready0);
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    in_valid = 1'b1;
    in_data = V_CNT;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid0 !== 1'b0 || busy0 !== 1'b0 || in_ready0 !== 1'b1 || busy1 !== 1'b0) begin
      errors++; $display("FAIL rstmid_state: got ov=%b busy=%b ir=%b expected 0 0 1", out_valid0, busy0, in_ready0);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid0 || out_valid1) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL rstmid_no_output: got %0d valid cycles expected 0", seen); end
    xfer(V_ZERO, S_ZERO, "after_reset");
  endtask

  task automatic test_in_valid_pulse();
    int n = 0;
    int extra = 0;
    in_valid = 1'b1;
    in_data = V_CNT;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1;
    in_data = V_ONES;
    tick();
    in_valid = 1'b0;
    in_data = V_ZERO;
    while (!out_valid0 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 2) begin errors++; $display("FAIL pulse_latency: got %0d expected 2", n); end
    checks++;
    if (out_data0 !== S_CNT || out_data1 !== S_CNT) begin
      errors++; $display("FAIL pulse_data: got %h/%h expected %h", out_data0, out_data1, S_CNT);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid0 || busy0) extra++;
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL pulse_no_second: got %0d active cycles expected 0", extra); end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_involution();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_in_valid_pulse();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
